// File: rtl/imem_program_loader.sv
//==============================================================================
// Module   : imem_program_loader
// Purpose  : Packs a 2-byte compact instruction stream into 27-bit imem words.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module imem_program_loader #(
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [26:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              full,
  output logic              err_illegal,
  output logic [ADDR_W:0]   word_count
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_B0   = 3'd1;
  localparam logic [2:0] S_B1   = 3'd2;
  localparam logic [2:0] S_WR   = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [4:0]        MAX_OP    = 5'd22;

  logic [2:0]        state_q, state_d;
  logic [7:0]        byte0_q, byte0_d;
  logic [26:0]       wdata_q, wdata_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              done_q, done_d;
  logic              full_q, full_d;
  logic              err_q, err_d;
  logic              rx_ready_q, busy_q, we_q;

  logic              w_xfer;
  logic              w_end;
  logic              w_illegal;
  logic [4:0]        w_idx;
  logic [22:0]       w_op;

  assign w_xfer    = rx_valid && rx_ready_q;
  assign w_idx     = rx_data[4:0];
  assign w_end     = (byte0_q == 8'hFF) && (rx_data == 8'hFF);
  assign w_illegal = (rx_data[7:5] != 3'b000) || (w_idx > MAX_OP) || (byte0_q[3:0] != 4'b0000);
  // op_idx 0 is NOOP (all-zero op); 1..22 select one-hot bit idx-1
  assign w_op      = ((w_idx == 5'd0) || (w_idx > MAX_OP)) ? 23'd0 : (23'd1 << (w_idx - 5'd1));

  always_comb begin
    state_d = state_q;
    byte0_d = byte0_q;
    wdata_d = wdata_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    full_d  = full_q;
    err_d   = err_q;

    case (state_q)
      S_IDLE: ;
      S_B0: begin
        if (w_xfer) begin
          byte0_d = rx_data;
          state_d = S_B1;
        end
      end
      S_B1: begin
        if (w_xfer) begin
          if (w_end) begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end else if (w_illegal) begin
            err_d   = 1'b1;
            state_d = S_B0;
          end else begin
            wdata_d = {byte0_q[7:4], w_op};
            state_d = S_WR;
          end
        end
      end
      S_WR: begin
        cnt_d = cnt_q + (ADDR_W+1)'(1);
        // address saturates at the last word so it never leaves the memory
        if (addr_q == LAST_ADDR) begin
          full_d  = 1'b1;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          addr_d  = addr_q + ADDR_W'(1);
          state_d = S_B0;
        end
      end
      S_DONE: ;
      default: state_d = S_IDLE;
    endcase

    // restart wins over everything; a write already on the port still completes
    if (load_start) begin
      state_d = S_B0;
      addr_d  = '0;
      cnt_d   = '0;
      done_d  = 1'b0;
      full_d  = 1'b0;
      err_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      byte0_q    <= '0;
      wdata_q    <= '0;
      addr_q     <= '0;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      full_q     <= 1'b0;
      err_q      <= 1'b0;
      rx_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      we_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte0_q    <= byte0_d;
      wdata_q    <= wdata_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      full_q     <= full_d;
      err_q      <= err_d;
      rx_ready_q <= (state_d == S_B0) || (state_d == S_B1);
      busy_q     <= (state_d == S_B0) || (state_d == S_B1) || (state_d == S_WR);
      we_q       <= (state_d == S_WR);
    end
  end

  assign rx_ready    = rx_ready_q;
  assign imem_we     = we_q;
  assign imem_addr   = addr_q;
  assign imem_wdata  = wdata_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign full        = full_q;
  assign err_illegal = err_q;
  assign word_count  = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_imem_program_loader.sv
//==============================================================================
// Module   : tb_imem_program_loader
// Purpose  : Scoreboard bench for imem_program_loader (DEPTH=4 instance).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_imem_program_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        imem_we;
  logic [5:0]  imem_addr;
  logic [26:0] imem_wdata;
  logic        busy;
  logic        done;
  logic        full;
  logic        err_illegal;
  logic [6:0]  word_count;

  typedef struct packed {
    logic [5:0]  a;
    logic [26:0] d;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  imem_program_loader #(.ADDR_W(6), .DEPTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .load_start  (load_start),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .imem_we     (imem_we),
    .imem_addr   (imem_addr),
    .imem_wdata  (imem_wdata),
    .busy        (busy),
    .done        (done),
    .full        (full),
    .err_illegal (err_illegal),
    .word_count  (word_count)
  );

  always #5 clk = ~clk;

  // every observed write must match the oldest expected one
  always @(negedge clk) begin
    if (!rst && imem_we) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_write: addr=%0d wdata=%h, none expected", imem_addr, imem_wdata);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if ({imem_addr, imem_wdata} !== {e.a, e.d}) begin
          n_bad++;
          $display("FAIL write: got addr=%0d wdata=%h, want addr=%0d wdata=%h", imem_addr, imem_wdata, e.a, e.d);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    while (!rx_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!rx_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: rx_ready=%b want 1 for byte %h", rx_ready, b);
    end
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_gap(input logic [7:0] b);
    @(posedge clk);
    #1;
    send_byte(b);
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1;
    load_start = 1'b1;
    @(posedge clk);
    #1;
    load_start = 1'b0;
  endtask

  task automatic check_queue_empty(input string tag);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL %s_pending: %0d writes missing, want 0", tag, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    #2;
    n_cmp++;
    if ({rx_ready, imem_we, imem_addr, imem_wdata, busy, done, full, err_illegal, word_count} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h want 0",
               {rx_ready, imem_we, imem_addr, imem_wdata, busy, done, full, err_illegal, word_count});
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++;
    if ({rx_ready, busy, imem_we} !== 3'b000) begin
      n_bad++;
      $display("FAIL idle_after_reset: got rdy/busy/we=%b want 000", {rx_ready, busy, imem_we});
    end
  endtask

  task automatic test_single_add();
    pulse_start();
    n_cmp++;
    if ({rx_ready, busy} !== 2'b11) begin
      n_bad++;
      $display("FAIL b0_flags: got rdy/busy=%b want 11", {rx_ready, busy});
    end
    exp_q.push_back('{a: 6'd0, d: 27'h3000040});
    send_byte(8'h60);
    send_byte(8'h07);
    n_cmp++;
    if (imem_we !== 1'b1) begin
      n_bad++;
      $display("FAIL write_latency: imem_we=%b want 1 one cycle after byte1", imem_we);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if ({imem_we, word_count, imem_addr, rx_ready} !== {1'b0, 7'd1, 6'd1, 1'b1}) begin
      n_bad++;
      $display("FAIL add_after_write: got we=%b cnt=%0d addr=%0d rdy=%b want 0 1 1 1",
               imem_we, word_count, imem_addr, rx_ready);
    end
    check_queue_empty("add");
  endtask

  task automatic test_end_marker();
    pulse_start();
    n_cmp++;
    if (word_count !== 7'd0) begin
      n_bad++;
      $display("FAIL restart_count: got %0d want 0", word_count);
    end
    exp_q.push_back('{a: 6'd0, d: 27'h0020000});
    send_byte(8'h00);
    send_byte(8'h12);
    send_byte(8'hFF);
    send_byte(8'hFF);
    n_cmp++;
    if ({done, full, busy, rx_ready, word_count} !== {4'b1000, 7'd1}) begin
      n_bad++;
      $display("FAIL end_marker: got done/full/busy/rdy=%b cnt=%0d want 1000 1",
               {done, full, busy, rx_ready}, word_count);
    end
    check_queue_empty("end_marker");
  endtask

  task automatic test_illegal();
    pulse_start();
    n_cmp++;
    if (done !== 1'b0) begin
      n_bad++;
      $display("FAIL done_cleared: got %b want 0", done);
    end
    send_byte(8'h00);
    send_byte(8'h17);
    n_cmp++;
    if ({err_illegal, imem_we, rx_ready} !== 3'b101) begin
      n_bad++;
      $display("FAIL illegal_op: got err/we/rdy=%b want 101", {err_illegal, imem_we, rx_ready});
    end
    send_byte(8'h05);
    send_byte(8'h01);
    n_cmp++;
    if ({err_illegal, imem_we} !== 2'b10) begin
      n_bad++;
      $display("FAIL illegal_low_nibble: got err/we=%b want 10", {err_illegal, imem_we});
    end
    exp_q.push_back('{a: 6'd0, d: 27'h0000001});
    send_byte(8'h00);
    send_byte(8'h01);
    @(posedge clk);
    #1;
    n_cmp++;
    if ({word_count, err_illegal} !== {7'd1, 1'b1}) begin
      n_bad++;
      $display("FAIL illegal_then_legal: got cnt=%0d err=%b want 1 1", word_count, err_illegal);
    end
    check_queue_empty("illegal");
  endtask

  task automatic test_full();
    logic [7:0]  b0 [4];
    logic [7:0]  b1 [4];
    logic [26:0] wd [4];
    b0 = '{8'hC0, 8'h30, 8'h00, 8'hF0};
    b1 = '{8'h00, 8'h16, 8'h01, 8'h0A};
    wd = '{27'h6000000, 27'h1A00000, 27'h0000001, 27'h7800200};
    pulse_start();
    n_cmp++;
    if (err_illegal !== 1'b0) begin
      n_bad++;
      $display("FAIL err_cleared: got %b want 0", err_illegal);
    end
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back('{a: 6'(i), d: wd[i]});
      send_byte(b0[i]);
      send_byte(b1[i]);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if ({full, done, rx_ready, busy, word_count, imem_addr} !== {4'b1100, 7'd4, 6'd3}) begin
      n_bad++;
      $display("FAIL full: got full/done/rdy/busy=%b cnt=%0d addr=%0d want 1100 4 3",
               {full, done, rx_ready, busy}, word_count, imem_addr);
    end
    rx_data  = 8'h00;
    rx_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_cmp++;
      if (rx_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL full_accepts: rx_ready=%b want 0", rx_ready);
      end
    end
    rx_valid = 1'b0;
    check_queue_empty("full");
  endtask

  task automatic test_restart_toggle();
    pulse_start();
    send_gap(8'h40);
    load_start = 1'b1;
    @(posedge clk);
    #1;
    load_start = 1'b0;
    exp_q.push_back('{a: 6'd0, d: 27'h0000010});
    send_gap(8'h00);
    send_gap(8'h05);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    n_cmp++;
    if ({word_count, imem_addr, err_illegal} !== {7'd1, 6'd1, 1'b0}) begin
      n_bad++;
      $display("FAIL restart_toggle: got cnt=%0d addr=%0d err=%b want 1 1 0", word_count, imem_addr, err_illegal);
    end
    check_queue_empty("restart_toggle");
  endtask

  task automatic test_restart_in_wr();
    pulse_start();
    exp_q.push_back('{a: 6'd0, d: 27'h0000004});
    send_byte(8'h00);
    send_byte(8'h03);
    load_start = 1'b1;
    @(posedge clk);
    #1;
    load_start = 1'b0;
    n_cmp++;
    if ({word_count, imem_addr, busy, imem_we} !== {7'd0, 6'd0, 2'b10}) begin
      n_bad++;
      $display("FAIL restart_in_wr: got cnt=%0d addr=%0d busy/we=%b want 0 0 10",
               word_count, imem_addr, {busy, imem_we});
    end
    exp_q.push_back('{a: 6'd0, d: 27'h0000008});
    send_byte(8'h00);
    send_byte(8'h04);
    @(posedge clk);
    #1;
    check_queue_empty("restart_in_wr");
  endtask

  task automatic test_rst_mid_wr();
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h01);
    n_cmp++;
    if (imem_we !== 1'b1) begin
      n_bad++;
      $display("FAIL pre_rst_write: imem_we=%b want 1", imem_we);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({rx_ready, imem_we, imem_addr, imem_wdata, busy, done, full, err_illegal, word_count} !== '0) begin
      n_bad++;
      $display("FAIL async_rst: got %h want 0",
               {rx_ready, imem_we, imem_addr, imem_wdata, busy, done, full, err_illegal, word_count});
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    n_cmp++;
    if ({rx_ready, busy, imem_we, done} !== 4'b0000) begin
      n_bad++;
      $display("FAIL idle_after_rst: got rdy/busy/we/done=%b want 0000", {rx_ready, busy, imem_we, done});
    end
    check_queue_empty("rst_mid_wr");
  endtask

  initial begin
    rst        = 1'b1;
    load_start = 1'b0;
    rx_data    = 8'h00;
    rx_valid   = 1'b0;
    test_reset();
    test_single_add();
    test_end_marker();
    test_illegal();
    test_full();
    test_restart_toggle();
    test_restart_in_wr();
    test_rst_mid_wr();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
